// File: rtl/chromite_stage0_pcgen.sv
// Stage 0 of the Chromite RV64 pipeline: fetch PC generation.
// Keeps the fetch PC, the execute/writeback epochs, the pending fence/sfence
// flags and a one-deep delayed-redirect slot. Issues one fetch request per
// cycle, steered by the branch predictor, and takes flush redirects from
// later stages.
module chromite_stage0_pcgen #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_0000_1000
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [1:0]      fetch_epoch,
  output logic            fetch_fence,
  output logic            fetch_sfence,
  input  logic            bpu_resp_valid,
  input  logic            bpu_resp_taken,
  input  logic            bpu_resp_edge,
  input  logic [XLEN-1:0] bpu_resp_target,
  input  logic            flush_valid,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            flush_fence,
  input  logic            flush_sfence,
  input  logic            update_eepoch,
  input  logic            update_wepoch
);

  localparam logic [XLEN-3:0] SEQ_INC = {{(XLEN-3){1'b0}}, 1'b1};

  logic [XLEN-1:0] rg_pc;
  logic            rg_eEpoch;
  logic            rg_wEpoch;
  logic            rg_fence;
  logic            rg_sfence;
  // {valid, target}: a taken branch whose redirect waits one fetch
  logic [XLEN:0]   rg_delayed_redirect;

  logic [XLEN-1:0] seq_pc;
  logic            accept;
  logic            bpu_taken;
  logic [XLEN-1:0] pc_nxt;
  logic            fence_nxt;
  logic            sfence_nxt;
  logic [XLEN:0]   dly_nxt;

  // The "_N" name is historical: RST_N is active-high, so requests are
  // only presented while it is low.
  assign fetch_valid  = ~RST_N;
  assign fetch_pc     = rg_pc;
  assign fetch_epoch  = {rg_eEpoch, rg_wEpoch};
  assign fetch_fence  = rg_fence;
  assign fetch_sfence = rg_sfence;

  // 4-byte aligned sequential successor, wrapping at the top of memory
  assign seq_pc    = {rg_pc[XLEN-1:2] + SEQ_INC, 2'b00};
  assign accept    = fetch_valid & fetch_ready & ~flush_valid;
  assign bpu_taken = bpu_resp_valid & bpu_resp_taken;

  // Next PC / fence / delayed-slot selection: flush beats accept, stall holds
  always_comb begin
    pc_nxt     = rg_pc;
    fence_nxt  = rg_fence;
    sfence_nxt = rg_sfence;
    dly_nxt    = rg_delayed_redirect;
    if (flush_valid) begin
      pc_nxt     = {flush_pc[XLEN-1:1], 1'b0};
      fence_nxt  = flush_fence;
      sfence_nxt = flush_sfence;
      dly_nxt    = '0;
    end else if (accept) begin
      fence_nxt  = 1'b0;
      sfence_nxt = 1'b0;
      if (rg_delayed_redirect[XLEN]) begin
        pc_nxt  = rg_delayed_redirect[XLEN-1:0];
        dly_nxt = '0;
      end else if (rg_fence | rg_sfence) begin
        pc_nxt = seq_pc;
      end else if (bpu_taken & bpu_resp_edge) begin
        // Fetch the word holding the branch's tail first, then redirect
        pc_nxt  = seq_pc;
        dly_nxt = {1'b1, bpu_resp_target};
      end else if (bpu_taken) begin
        pc_nxt = bpu_resp_target;
      end else begin
        pc_nxt = seq_pc;
      end
    end
  end

  // PC, fence flags and delayed slot registers
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      rg_pc               <= RESET_PC;
      rg_fence            <= 1'b0;
      rg_sfence           <= 1'b0;
      rg_delayed_redirect <= '0;
    end else begin
      rg_pc               <= pc_nxt;
      rg_fence            <= fence_nxt;
      rg_sfence           <= sfence_nxt;
      rg_delayed_redirect <= dly_nxt;
    end
  end

  // Epoch bits toggle independently of fetch traffic
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      rg_eEpoch <= 1'b0;
      rg_wEpoch <= 1'b0;
    end else begin
      rg_eEpoch <= rg_eEpoch ^ update_eepoch;
      rg_wEpoch <= rg_wEpoch ^ update_wepoch;
    end
  end

endmodule

// File: tb/tb_chromite_stage0_pcgen.sv
// Scoreboard bench for chromite_stage0_pcgen: the stimulus process queues the
// expected fetch request for each cycle, the monitor pops and compares it.
module tb_chromite_stage0_pcgen;

  localparam int XLEN = 64;

  logic            CLK;
  logic            RST_N;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic [1:0]      fetch_epoch;
  logic            fetch_fence;
  logic            fetch_sfence;
  logic            bpu_resp_valid;
  logic            bpu_resp_taken;
  logic            bpu_resp_edge;
  logic [XLEN-1:0] bpu_resp_target;
  logic            flush_valid;
  logic [XLEN-1:0] flush_pc;
  logic            flush_fence;
  logic            flush_sfence;
  logic            update_eepoch;
  logic            update_wepoch;

  chromite_stage0_pcgen #(.XLEN(XLEN), .RESET_PC(64'h1000)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_epoch(fetch_epoch), .fetch_fence(fetch_fence), .fetch_sfence(fetch_sfence),
    .bpu_resp_valid(bpu_resp_valid), .bpu_resp_taken(bpu_resp_taken),
    .bpu_resp_edge(bpu_resp_edge), .bpu_resp_target(bpu_resp_target),
    .flush_valid(flush_valid), .flush_pc(flush_pc), .flush_fence(flush_fence),
    .flush_sfence(flush_sfence), .update_eepoch(update_eepoch),
    .update_wepoch(update_wepoch)
  );

  typedef struct {
    int              id;
    logic            v;
    logic [XLEN-1:0] pc;
    logic [1:0]      ep;
    logic            f;
    logic            sf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_id = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int id, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", name, id, act, req);
    end
  endtask

  // Monitor: compare the presented request against the queued expectation
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("valid", e.id, XLEN'(fetch_valid), XLEN'(e.v));
      chk("pc", e.id, fetch_pc, e.pc);
      chk("epoch", e.id, XLEN'(fetch_epoch), XLEN'(e.ep));
      chk("fence", e.id, XLEN'(fetch_fence), XLEN'(e.f));
      chk("sfence", e.id, XLEN'(fetch_sfence), XLEN'(e.sf));
    end
  end

  task automatic idle();
    RST_N = 1'b0; fetch_ready = 1'b1;
    bpu_resp_valid = 1'b0; bpu_resp_taken = 1'b0; bpu_resp_edge = 1'b0;
    bpu_resp_target = '0;
    flush_valid = 1'b0; flush_pc = '0; flush_fence = 1'b0; flush_sfence = 1'b0;
    update_eepoch = 1'b0; update_wepoch = 1'b0;
  endtask

  task automatic bpu(input logic edge_b, input logic [XLEN-1:0] tgt);
    bpu_resp_valid = 1'b1; bpu_resp_taken = 1'b1; bpu_resp_edge = edge_b;
    bpu_resp_target = tgt;
  endtask

  task automatic flush(input logic [XLEN-1:0] pc, input logic f, input logic sf);
    flush_valid = 1'b1; flush_pc = pc; flush_fence = f; flush_sfence = sf;
  endtask

  // Queue what the DUT should show this cycle, then advance one clock
  task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic [1:0] ep,
                      input logic f, input logic sf);
    exp_t e;
    e.id = cyc_id; e.v = v; e.pc = pc; e.ep = ep; e.f = f; e.sf = sf;
    exp_q.push_back(e);
    cyc_id++;
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(); RST_N = 1'b1;
    @(posedge CLK); #1;
    // reset held: request invalid, PC at reset vector
    idle(); RST_N = 1'b1;                      step(0, 64'h1000, 2'b00, 0, 0);
    // sequential fetch
    idle();                                    step(1, 64'h1000, 2'b00, 0, 0);
    idle(); bpu(0, 64'h2000);                  step(1, 64'h1004, 2'b00, 0, 0);
    idle();                                    step(1, 64'h2000, 2'b00, 0, 0);
    // edge-straddling taken branch: one sequential fetch, then the target
    idle(); bpu(1, 64'h2100);                  step(1, 64'h2004, 2'b00, 0, 0);
    idle(); bpu(0, 64'h7000);                  step(1, 64'h2008, 2'b00, 0, 0);
    // stall for three cycles, BPU ignored
    idle(); fetch_ready = 0;                   step(1, 64'h2100, 2'b00, 0, 0);
    idle(); fetch_ready = 0; bpu(0, 64'h9000); step(1, 64'h2100, 2'b00, 0, 0);
    idle(); fetch_ready = 0;                   step(1, 64'h2100, 2'b00, 0, 0);
    // flush beats a simultaneous accept, bit 0 cleared
    idle(); flush(64'h3003, 1, 0);             step(1, 64'h2100, 2'b00, 0, 0);
    // pending fence forces sequential fetch despite a taken prediction
    idle(); bpu(0, 64'h8000);                  step(1, 64'h3002, 2'b00, 1, 0);
    // both epochs toggle together, then writeback alone
    idle(); update_eepoch = 1; update_wepoch = 1; step(1, 64'h3004, 2'b00, 0, 0);
    idle(); update_wepoch = 1;                 step(1, 64'h3008, 2'b11, 0, 0);
    // flush during a stall carrying sfence; sfence holds through stall
    idle(); fetch_ready = 0; flush(64'h5000, 0, 1); step(1, 64'h300C, 2'b10, 0, 0);
    idle(); fetch_ready = 0;                   step(1, 64'h5000, 2'b10, 0, 1);
    idle();                                    step(1, 64'h5000, 2'b10, 0, 1);
    // pending delayed redirect is discarded by a flush
    idle(); bpu(1, 64'h2000);                  step(1, 64'h5004, 2'b10, 0, 0);
    idle(); flush(64'h4000, 0, 0);             step(1, 64'h5008, 2'b10, 0, 0);
    idle();                                    step(1, 64'h4000, 2'b10, 0, 0);
    // top-of-memory wrap
    idle(); flush(64'hFFFF_FFFF_FFFF_FFFC, 0, 0); step(1, 64'h4004, 2'b10, 0, 0);
    idle();                                    step(1, 64'hFFFF_FFFF_FFFF_FFFC, 2'b10, 0, 0);
    // reset mid-stream overrides flush and epoch update
    idle(); RST_N = 1; flush(64'h6000, 1, 1); update_eepoch = 1;
                                               step(0, 64'h0, 2'b10, 0, 0);
    idle(); RST_N = 1;                         step(0, 64'h1000, 2'b00, 0, 0);
    idle();                                    step(1, 64'h1000, 2'b00, 0, 0);
    idle();                                    step(1, 64'h1004, 2'b00, 0, 0);
    @(negedge CLK); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chromite_stage0_pcgen.md
Name: chromite_stage0_pcgen

Overview:
- Stage-0 (PC generation) of the Chromite RV64 core pipeline.
- Holds the fetch PC, the execute/writeback epoch bits, the pending fence/sfence flags and a delayed-redirect slot.
- Each cycle it issues one fetch request to the I-cache/stage1, with branch-predictor (BPU) steering, and accepts flush redirects from later stages.
- Probed state names (rg_pc, rg_eEpoch, rg_wEpoch, rg_fence, rg_sfence, rg_delayed_redirect) are kept as internal register names.

Parameters:
- XLEN, 64, address/PC width.
- RESET_PC, 64'h0000_0000_0000_1000, PC loaded at reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous, active-high reset (asserted = 1, despite the name).
- fetch_valid  out  1  fetch request valid.
- fetch_ready  in  1  I-cache/stage1 accepts request.
- fetch_pc  out  XLEN  request address (= rg_pc).
- fetch_epoch  out  2  {rg_eEpoch, rg_wEpoch}.
- fetch_fence  out  1  request carries fence.i (= rg_fence).
- fetch_sfence  out  1  request carries sfence.vma (= rg_sfence).
- bpu_resp_valid  in  1  BPU has a prediction for fetch_pc (combinational, same cycle).
- bpu_resp_taken  in  1  predicted taken.
- bpu_resp_edge  in  1  taken branch straddles fetch word; redirect must be delayed one fetch.
- bpu_resp_target  in  XLEN  predicted target.
- flush_valid  in  1  redirect from later stage (ma_flush_fl).
- flush_pc  in  XLEN  redirect address.
- flush_fence  in  1  redirect is a fence.i.
- flush_sfence  in  1  redirect is an sfence.vma.
- update_eepoch  in  1  toggle rg_eEpoch.
- update_wepoch  in  1  toggle rg_wEpoch.

Behaviour:

Reset (RST_N=1 at a clock edge):
- rg_pc=RESET_PC; rg_eEpoch=0; rg_wEpoch=0; rg_fence=0; rg_sfence=0; delayed redirect invalid (target=0).
- fetch_valid=0 while RST_N=1. Reset overrides all other inputs, including mid-operation.

Outside reset:
- fetch_valid=1 every cycle.
- fetch_pc, fetch_epoch, fetch_fence and fetch_sfence are direct register outputs (no combinational path from inputs).

Sequential PC:
- seq = {rg_pc[XLEN-1:2]+1, 2'b00}, i.e. 4-byte aligned increment.
- Wraps modulo 2^XLEN to 0.

Accept (fetch_valid & fetch_ready & !flush_valid) — next PC, in priority order:
1. Delayed redirect valid: rg_pc <= stored target; delayed slot cleared; BPU ignored.
2. rg_fence | rg_sfence set: rg_pc <= seq; BPU ignored.
3. bpu_resp_valid & bpu_resp_taken & bpu_resp_edge: rg_pc <= seq; delayed slot <= {1, bpu_resp_target}.
4. bpu_resp_valid & bpu_resp_taken: rg_pc <= bpu_resp_target.
5. Otherwise: rg_pc <= seq.
- Every accept also clears rg_fence and rg_sfence.

Stall (fetch_valid & !fetch_ready & !flush_valid):
- All PC, fence and delayed state holds; outputs stable.
- BPU inputs ignored.

Flush (flush_valid=1):
- Highest priority after reset; wins over a simultaneous accept, whose request is dropped.
- rg_pc <= {flush_pc[XLEN-1:1], 1'b0}; rg_fence <= flush_fence; rg_sfence <= flush_sfence; delayed slot cleared.
- A fetch_valid request may change without being accepted on a flush cycle.

Epochs:
- update_eepoch toggles rg_eEpoch; update_wepoch toggles rg_wEpoch.
- Independent of each other and of flush, accept and stall; both may occur in the same cycle.
- New epoch value appears on fetch_epoch the cycle after the update.

Sizing: expected RTL 120–250 lines.

Test Plan:
1. Reset then release, fetch_ready=1, no BPU/flush -> fetch_pc sequence 0x1000, 0x1004, 0x1008; fetch_epoch=2'b00; fence/sfence=0.
2. At pc 0x1004: bpu taken, target 0x2000, edge=0, accepted -> next fetch_pc=0x2000. Repeat with edge=1 -> 0x1008, then 0x2000, even if BPU predicts at 0x1008.
3. fetch_ready=0 for 3 cycles at pc 0x1008, flush_valid=0 -> fetch_pc held at 0x1008. Then flush_valid=1, flush_pc=0x3003, flush_fence=1 in the same cycle as fetch_ready=1 -> fetch_pc=0x3002, fetch_fence=1. After that request is accepted -> 0x3004, fetch_fence=0.
4. update_eepoch and update_wepoch pulsed together -> fetch_epoch 00→11. Pulse update_wepoch alone -> 10.
5. Pending delayed redirect (target 0x2000) followed by flush to 0x4000 -> fetch_pc=0x4000, then 0x4004; 0x2000 is never issued.
6. rg_pc=0xFFFF_FFFF_FFFF_FFFC accepted -> fetch_pc=0. Assert RST_N mid-stream with flush_valid=1 -> fetch_pc=0x1000, epochs 00, fetch_valid=0 during reset.
